himem_remap_ctrl: RTL and testbench
===================================

Name: himem_remap_ctrl

Overview:
Parametrised successor to the single-window accelerator glue. Owns the mapping control registers and the BBC ROM page-register shadow. Remaps bank-0 accesses through NUM_WIN programmable 4 KB windows into any high bank, and paces the return to the high-speed clock after I/O accesses with a programmable delay counter. It sits between the 65816 bus decode (bank latch, VDA/VPA) and the clock-switch block.

Parameters:
NUM_WIN, 4, number of remap windows (1..6)
BANK_W, 8, width of bank address and remapped bank output
DLY_W, 4, width of I/O delay counter and DELAY register
PAGEREG_W, 4, ROM page-register shadow width
PAGEREG_ADR, 16'hFE30, bank-0 address of BBC ROM select register
IO_LO, 16'hFC00, first address of the delayed I/O region
IO_HI, 16'hFEDF, last address of the delayed I/O region

Ports:
clk  in  1  cycle clock; rising edge = end of CPU bus cycle
resetb  in  1  asynchronous, active-low reset
cyc_valid  in  1  VDA|VPA for the current cycle
cpu_sync  in  1  VDA&VPA (opcode fetch)
cpu_rnw  in  1  1 = read
cpu_bank  in  BANK_W  latched bank address
cpu_adr  in  16  CPU address
cpu_wdata  in  8  CPU write data
hs_selected  in  1  clock switch reports HS clock active
ls_selected  in  1  clock switch reports LS clock active
eff_bank  out  BANK_W  bank after remapping (combinational)
sel_hs  out  1  request HS clock (combinational)
dummy_access  out  1  force BBC-side dummy read (combinational)
reg_rd_en  out  1  block drives reg_rdata onto CPU data bus
reg_rdata  out  8  register readback
clk_div  out  2  CTRL[1:0], HS clock divider select
pagereg_q  out  PAGEREG_W  ROM page-register shadow

Behaviour:
- Register hit: cyc_valid & cpu_bank[BANK_W-1:BANK_W-2]==2'b10; index = cpu_adr[3:0]. Index 0 = CTRL, 1 = DELAY, 2+2i = WIN_i_CFG, 3+2i = WIN_i_BANK. Indices at or beyond 2+2*NUM_WIN read 0; writes to them are ignored.
- CTRL: bit2 hs_en, bits1:0 clk_div; other bits read 0. WIN_i_CFG: bit7 enable, bit6 slow_wr, bit5 mos_byp, bits3:0 page (cpu_adr[15:12] match); bit4 reads 0.
- Writes take effect on the rising clk where hit & !cpu_rnw. reg_rd_en = hit & cpu_rnw; reg_rdata is combinational.
- Page shadow: on a rising clk with cyc_valid & !cpu_rnw & !cpu_bank[BANK_W-1] & cpu_adr==PAGEREG_ADR, pagereg_q <= cpu_wdata[PAGEREG_W-1:0].
- Window match i: cpu_bank==0 & cyc_valid & enable_i & page_i==cpu_adr[15:12]. The lowest matching index wins. On a match, eff_bank = WIN_i_BANK; otherwise eff_bank = cpu_bank.
- slow_w: the winning window has slow_wr=1 & !cpu_rnw.
- himem = cyc_valid & eff_bank[BANK_W-1] & !slow_w.
- I/O delay counter dcnt (DLY_W bits):
  - io_hit = cyc_valid & !cpu_bank[BANK_W-1] & IO_LO<=cpu_adr<=IO_HI.
  - On clk: if io_hit, dcnt <= DELAY; else if dcnt!=0, dcnt <= dcnt-1. dcnt saturates at 0.
  - io_hit while counting reloads dcnt. A DELAY write while counting applies only at the next load.
- sel_hs = hs_en & ((cpu_sync & eff_bank[BANK_W-1] & dcnt==0) | (himem & hs_selected) | (!cyc_valid & hs_selected)).
- dummy_access = himem | !ls_selected.
- Reset (async, any time, including mid-count): CTRL, DELAY, all WIN regs, pagereg_q, dcnt and mos_q <= 0. Consequences: eff_bank = cpu_bank, sel_hs = 0, clk_div = 0, reg_rd_en follows decode.
- Simultaneous register write and window use in the same cycle: the window decode uses pre-write values, so the new values apply from the next cycle.

Optional Feature:
MOS_VDU_BYPASS_EN.
- When defined, mos_q updates on clk whenever cpu_sync: mos_q <= !cpu_bank[0] & cpu_adr[15:13]==3'b110.
- A window with mos_byp=1 does not match while mos_q=1, so MOS VDU code reaches real screen memory.
- When undefined, mos_q is absent, mos_byp is stored and read back but has no effect, and windows match regardless.

Test Plan:
- Reset, then write CTRL=0x07 (bank 0x80, adr 0) and WIN0_CFG=0xC3, WIN0_BANK=0xFE -> readback 0x07/0xC3/0xFE; clk_div=3; undefined index 0xF reads 0x00.
- WIN0 page 3 →0xFE, WIN1 page 3 →0xFD, both enabled; read bank 0 adr 0x3123 -> eff_bank=0xFE; disable WIN0 -> eff_bank=0xFD; adr 0x4000 -> eff_bank=0x00.
- DELAY=5, hs_en=1, hs_selected=0; access bank 0 adr 0xFE40, then sync fetches from bank 0xFF -> sel_hs=0 for 5 cycles, 1 on the 6th; second I/O access at cycle 3 reloads dcnt to 5.
- WIN0 slow_wr=1 →0xFE; write bank 0 adr 0x3000 -> himem=0, dummy_access=!ls_selected; a read of the same address -> himem=1, dummy_access=1.
- Write 0x0F to bank 0 adr 0xFE30 -> pagereg_q=0xF; assert resetb low mid DELAY count -> dcnt=0, pagereg_q=0, eff_bank=cpu_bank immediately.
- (MOS_VDU_BYPASS_EN) WIN0 mos_byp=1 page 3; fetch opcode from bank 0 adr 0xC800, then write 0x3000 -> eff_bank=0x00; fetch from 0x8000, then write 0x3000 -> eff_bank=WIN0_BANK.

Source files
------------

// File: rtl/himem_remap_ctrl.sv
// himem_remap_ctrl: NUM_WIN-window bank-0 remapper, BBC ROM page shadow and post-I/O HS clock pacing.
// Optional feature macro MOS_VDU_BYPASS_EN: windows with mos_byp set are suppressed while MOS VDU code runs.
module himem_remap_ctrl #(
    parameter int          NUM_WIN     = 4,
    parameter int          BANK_W      = 8,
    parameter int          DLY_W       = 4,
    parameter int          PAGEREG_W   = 4,
    parameter logic [15:0] PAGEREG_ADR = 16'hFE30,
    parameter logic [15:0] IO_LO       = 16'hFC00,
    parameter logic [15:0] IO_HI       = 16'hFEDF
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 cyc_valid,
    input  logic                 cpu_sync,
    input  logic                 cpu_rnw,
    input  logic [BANK_W-1:0]    cpu_bank,
    input  logic [15:0]          cpu_adr,
    input  logic [7:0]           cpu_wdata,
    input  logic                 hs_selected,
    input  logic                 ls_selected,
    output logic [BANK_W-1:0]    eff_bank,
    output logic                 sel_hs,
    output logic                 dummy_access,
    output logic                 reg_rd_en,
    output logic [7:0]           reg_rdata,
    output logic [1:0]           clk_div,
    output logic [PAGEREG_W-1:0] pagereg_q
);

    logic [2:0]        ctrl_q;
    logic [DLY_W-1:0]  delay_q;
    logic [DLY_W-1:0]  dcnt_q;
    logic [DLY_W-1:0]  dcnt_d;
    logic [7:0]        win_cfg_q  [NUM_WIN];
    logic [BANK_W-1:0] win_bank_q [NUM_WIN];

    logic              reg_hit;
    logic              reg_wr;
    logic [3:0]        reg_idx;
    logic [BANK_W-1:0] wdata_bank;
    logic [DLY_W-1:0]  wdata_delay;
    logic              win_hit;
    logic              win_slow;
    logic [BANK_W-1:0] win_bank_sel;
    logic              slow_w;
    logic              himem;
    logic              io_hit;
    logic              page_wr;
    logic              mos_active;

    assign reg_hit   = cyc_valid & (cpu_bank[BANK_W-1 -: 2] == 2'b10);
    assign reg_wr    = reg_hit & ~cpu_rnw;
    assign reg_idx   = cpu_adr[3:0];
    assign reg_rd_en = reg_hit & cpu_rnw;
    assign clk_div   = ctrl_q[1:0];

    // Write data zero-extended or truncated to the register widths.
    always_comb begin
        wdata_bank  = '0;
        wdata_delay = '0;
        for (int b = 0; b < BANK_W && b < 8; b++) wdata_bank[b] = cpu_wdata[b];
        for (int b = 0; b < DLY_W && b < 8; b++) wdata_delay[b] = cpu_wdata[b];
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ctrl_q  <= '0;
            delay_q <= '0;
            for (int i = 0; i < NUM_WIN; i++) begin
                win_cfg_q[i]  <= '0;
                win_bank_q[i] <= '0;
            end
        end else if (reg_wr) begin
            if (reg_idx == 4'd0) ctrl_q <= cpu_wdata[2:0];
            if (reg_idx == 4'd1) delay_q <= wdata_delay;
            for (int i = 0; i < NUM_WIN; i++) begin
                if (reg_idx == 4'(2 + 2 * i)) win_cfg_q[i] <= cpu_wdata & 8'hEF;
                if (reg_idx == 4'(3 + 2 * i)) win_bank_q[i] <= wdata_bank;
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (reg_idx == 4'd0) reg_rdata = {5'b0, ctrl_q};
        if (reg_idx == 4'd1) begin
            for (int b = 0; b < DLY_W && b < 8; b++) reg_rdata[b] = delay_q[b];
        end
        for (int i = 0; i < NUM_WIN; i++) begin
            if (reg_idx == 4'(2 + 2 * i)) reg_rdata = win_cfg_q[i];
            if (reg_idx == 4'(3 + 2 * i)) begin
                for (int b = 0; b < BANK_W && b < 8; b++) reg_rdata[b] = win_bank_q[i][b];
            end
        end
    end

`ifdef MOS_VDU_BYPASS_EN
    logic mos_q;
    logic mos_d;

    assign mos_d      = cpu_sync ? (~cpu_bank[0] & (cpu_adr[15:13] == 3'b110)) : mos_q;
    assign mos_active = mos_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) mos_q <= 1'b0;
        else         mos_q <= mos_d;
    end
`else
    assign mos_active = 1'b0;
`endif

    // Lowest-numbered matching window wins; decode always sees the pre-write register values.
    always_comb begin
        win_hit      = 1'b0;
        win_slow     = 1'b0;
        win_bank_sel = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (!win_hit && cyc_valid && (cpu_bank == '0) && win_cfg_q[i][7] &&
                (win_cfg_q[i][3:0] == cpu_adr[15:12]) && !(win_cfg_q[i][5] && mos_active)) begin
                win_hit      = 1'b1;
                win_slow     = win_cfg_q[i][6];
                win_bank_sel = win_bank_q[i];
            end
        end
    end

    assign eff_bank     = win_hit ? win_bank_sel : cpu_bank;
    assign slow_w       = win_hit & win_slow & ~cpu_rnw;
    assign himem        = cyc_valid & eff_bank[BANK_W-1] & ~slow_w;
    assign dummy_access = himem | ~ls_selected;
    assign sel_hs       = ctrl_q[2] & ((cpu_sync & eff_bank[BANK_W-1] & (dcnt_q == '0)) |
                                       (himem & hs_selected) | (~cyc_valid & hs_selected));

    assign io_hit  = cyc_valid & ~cpu_bank[BANK_W-1] & (cpu_adr >= IO_LO) & (cpu_adr <= IO_HI);
    assign page_wr = cyc_valid & ~cpu_rnw & ~cpu_bank[BANK_W-1] & (cpu_adr == PAGEREG_ADR);

    // I/O accesses (re)load the delay; otherwise count down to zero and hold.
    always_comb begin
        dcnt_d = dcnt_q;
        if (io_hit)              dcnt_d = delay_q;
        else if (dcnt_q != '0)   dcnt_d = dcnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dcnt_q    <= '0;
            pagereg_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
            if (page_wr) pagereg_q <= cpu_wdata[PAGEREG_W-1:0];
        end
    end

endmodule

// File: tb/tb_himem_remap_ctrl.sv
// tb_himem_remap_ctrl: directed scenarios plus randomized bus traffic checked against a register-level model.
module tb_himem_remap_ctrl;

    localparam int NW = 4;
`ifdef MOS_VDU_BYPASS_EN
    localparam bit MosEn = 1'b1;
`else
    localparam bit MosEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetb;
    logic        cycValid, cpuSync, cpuRnw;
    logic [7:0]  cpuBank;
    logic [15:0] cpuAdr;
    logic [7:0]  cpuWdata;
    logic        hsSel, lsSel;
    logic [7:0]  effBank;
    logic        selHs, dummyAccess, regRdEn;
    logic [7:0]  regRdata;
    logic [1:0]  clkDiv;
    logic [3:0]  pageReg;

    int assertCount = 0;
    int failCount   = 0;

    int mCtrl, mDelay, mPage, mDcnt;
    int mCfg  [NW];
    int mBank [NW];
    bit mMos;

    always #5 clk = ~clk;

    himem_remap_ctrl #(.NUM_WIN(NW)) dut (
        .clk(clk), .resetb(resetb), .cyc_valid(cycValid), .cpu_sync(cpuSync),
        .cpu_rnw(cpuRnw), .cpu_bank(cpuBank), .cpu_adr(cpuAdr), .cpu_wdata(cpuWdata),
        .hs_selected(hsSel), .ls_selected(lsSel), .eff_bank(effBank), .sel_hs(selHs),
        .dummy_access(dummyAccess), .reg_rd_en(regRdEn), .reg_rdata(regRdata),
        .clk_div(clkDiv), .pagereg_q(pageReg)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void resetModel();
        mCtrl = 0; mDelay = 0; mPage = 0; mDcnt = 0; mMos = 1'b0;
        for (int w = 0; w < NW; w++) begin
            mCfg[w]  = 0;
            mBank[w] = 0;
        end
    endfunction

    function automatic int modelWin();
        if (!cycValid || cpuBank != 8'h00) return -1;
        for (int w = 0; w < NW; w++) begin
            if (((mCfg[w] >> 7) & 1) == 1 && (mCfg[w] & 15) == int'(cpuAdr[15:12]) &&
                !(MosEn && ((mCfg[w] >> 5) & 1) == 1 && mMos))
                return w;
        end
        return -1;
    endfunction

    function automatic int modelEff();
        int w = modelWin();
        return (w >= 0) ? mBank[w] : int'(cpuBank);
    endfunction

    function automatic bit modelHimem();
        int w = modelWin();
        bit slow = (w >= 0) && (((mCfg[w] >> 6) & 1) == 1) && !cpuRnw;
        return cycValid && (((modelEff() >> 7) & 1) == 1) && !slow;
    endfunction

    function automatic bit modelSelHs();
        bit hsEn = ((mCtrl >> 2) & 1) == 1;
        bit hiBank = ((modelEff() >> 7) & 1) == 1;
        return hsEn && ((cpuSync && hiBank && mDcnt == 0) || (modelHimem() && hsSel) || (!cycValid && hsSel));
    endfunction

    function automatic bit modelRegHit();
        return cycValid && cpuBank >= 8'h80 && cpuBank <= 8'hBF;
    endfunction

    function automatic int modelRdata();
        int idx = int'(cpuAdr[3:0]);
        if (idx == 0) return mCtrl;
        if (idx == 1) return mDelay;
        if (idx >= 2 && idx < 2 + 2 * NW) return (idx % 2 == 0) ? mCfg[(idx - 2) / 2] : mBank[(idx - 2) / 2];
        return 0;
    endfunction

    function automatic void modelUpdate();
        int idx = int'(cpuAdr[3:0]);
        bit lowBank = cpuBank < 8'h80;
        if (modelRegHit() && !cpuRnw) begin
            if (idx == 0) mCtrl = int'(cpuWdata) & 7;
            else if (idx == 1) mDelay = int'(cpuWdata) & 15;
            else if (idx < 2 + 2 * NW) begin
                if (idx % 2 == 0) mCfg[(idx - 2) / 2] = int'(cpuWdata) & 8'hEF;
                else              mBank[(idx - 2) / 2] = int'(cpuWdata);
            end
        end
        if (cycValid && !cpuRnw && lowBank && cpuAdr == 16'hFE30) mPage = int'(cpuWdata) & 15;
        if (cycValid && lowBank && cpuAdr >= 16'hFC00 && cpuAdr <= 16'hFEDF) mDcnt = mDelay;
        else if (mDcnt > 0) mDcnt = mDcnt - 1;
        if (cpuSync) mMos = (cpuBank[0] == 1'b0) && (cpuAdr[15:13] == 3'b110);
    endfunction

    // Drives one bus cycle mid-period and checks every output against the model.
    task automatic applyStimulus(input bit v, input bit s, input bit r, input logic [7:0] b,
                                 input logic [15:0] a, input logic [7:0] wd, input bit hs, input bit ls);
        @(negedge clk);
        cycValid = v; cpuSync = s; cpuRnw = r; cpuBank = b; cpuAdr = a; cpuWdata = wd;
        hsSel = hs; lsSel = ls;
        #1;
        checkOutput("eff_bank", 32'(effBank), 32'(modelEff()));
        checkOutput("sel_hs", 32'(selHs), 32'(modelSelHs()));
        checkOutput("dummy_access", 32'(dummyAccess), 32'(modelHimem() || !ls));
        checkOutput("reg_rd_en", 32'(regRdEn), 32'(modelRegHit() && r));
        if (modelRegHit() && r) checkOutput("reg_rdata", 32'(regRdata), 32'(modelRdata()));
        checkOutput("clk_div", 32'(clkDiv), 32'(mCtrl & 3));
        checkOutput("pagereg", 32'(pageReg), 32'(mPage));
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetb) modelUpdate();
    endtask

    task automatic cycle(input bit v, input bit s, input bit r, input logic [7:0] b,
                         input logic [15:0] a, input logic [7:0] wd, input bit hs, input bit ls);
        applyStimulus(v, s, r, b, a, wd, hs, ls);
        tick();
    endtask

    task automatic regWrite(input logic [3:0] idx, input logic [7:0] data);
        cycle(1, 0, 0, 8'h80, {12'h000, idx}, data, 0, 1);
    endtask

    task automatic regReadCheck(input string tag, input logic [3:0] idx, input logic [7:0] expected);
        applyStimulus(1, 0, 1, 8'h80, {12'h000, idx}, 8'h00, 0, 1);
        checkOutput(tag, 32'(regRdata), 32'(expected));
        tick();
    endtask

    initial begin
        logic [31:0] rnd;
        logic [7:0]  b;
        logic [15:0] a;

        resetb = 1'b0;
        cycValid = 0; cpuSync = 0; cpuRnw = 1; cpuBank = 8'h12; cpuAdr = 16'h0000;
        cpuWdata = 8'h00; hsSel = 1; lsSel = 1;
        resetModel();
        #12;
        checkOutput("rst eff_bank", 32'(effBank), 32'h12);
        checkOutput("rst clk_div", 32'(clkDiv), 32'h0);
        checkOutput("rst pagereg", 32'(pageReg), 32'h0);
        checkOutput("rst sel_hs", 32'(selHs), 32'h0);
        resetb = 1'b1;

        regWrite(4'h0, 8'h07);
        regWrite(4'h2, 8'hC3);
        regWrite(4'h3, 8'hFE);
        applyStimulus(1, 0, 1, 8'h80, 16'h0000, 8'h00, 0, 1);
        checkOutput("ctrl readback", 32'(regRdata), 32'h07);
        checkOutput("clk_div=3", 32'(clkDiv), 32'h3);
        tick();
        regReadCheck("win0 cfg readback", 4'h2, 8'hC3);
        regReadCheck("win0 bank readback", 4'h3, 8'hFE);
        regReadCheck("undefined idx F", 4'hF, 8'h00);
        regReadCheck("idx past windows", 4'hA, 8'h00);

        regWrite(4'h4, 8'h83);
        regWrite(4'h5, 8'hFD);
        applyStimulus(1, 0, 1, 8'h00, 16'h3123, 8'h00, 0, 1);
        checkOutput("win0 priority", 32'(effBank), 32'hFE);
        tick();
        regWrite(4'h2, 8'h43);
        applyStimulus(1, 0, 1, 8'h00, 16'h3123, 8'h00, 0, 1);
        checkOutput("win1 after win0 off", 32'(effBank), 32'hFD);
        tick();
        applyStimulus(1, 0, 1, 8'h00, 16'h4000, 8'h00, 0, 1);
        checkOutput("no window match", 32'(effBank), 32'h00);
        tick();

        regWrite(4'h1, 8'h05);
        cycle(1, 0, 1, 8'h00, 16'hFE40, 8'h00, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1, 1, 1, 8'hFF, 16'h1000 + 16'(k), 8'h00, 0, 1);
            checkOutput("io delay sel_hs", 32'(selHs), 32'(k == 6));
            tick();
        end
        cycle(1, 0, 1, 8'h00, 16'hFC10, 8'h00, 0, 1);
        cycle(1, 1, 1, 8'hFF, 16'h2000, 8'h00, 0, 1);
        cycle(1, 1, 1, 8'hFF, 16'h2001, 8'h00, 0, 1);
        cycle(1, 0, 0, 8'h00, 16'hFEDF, 8'h00, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1, 1, 1, 8'hFF, 16'h2100 + 16'(k), 8'h00, 0, 1);
            checkOutput("io reload sel_hs", 32'(selHs), 32'(k == 6));
            tick();
        end

        regWrite(4'h2, 8'hC3);
        applyStimulus(1, 0, 0, 8'h00, 16'h3000, 8'h55, 0, 1);
        checkOutput("slow write dummy ls=1", 32'(dummyAccess), 32'h0);
        checkOutput("slow write eff_bank", 32'(effBank), 32'hFE);
        tick();
        applyStimulus(1, 0, 0, 8'h00, 16'h3000, 8'h55, 0, 0);
        checkOutput("slow write dummy ls=0", 32'(dummyAccess), 32'h1);
        tick();
        applyStimulus(1, 0, 1, 8'h00, 16'h3000, 8'h00, 0, 1);
        checkOutput("slow window read dummy", 32'(dummyAccess), 32'h1);
        tick();

        cycle(1, 0, 0, 8'h00, 16'hFE30, 8'h0F, 0, 1);
        applyStimulus(0, 0, 1, 8'h00, 16'h0000, 8'h00, 0, 1);
        checkOutput("pagereg shadow", 32'(pageReg), 32'hF);
        tick();

        cycle(1, 0, 1, 8'h00, 16'hFE40, 8'h00, 0, 1);
        applyStimulus(1, 0, 1, 8'h00, 16'h3123, 8'h00, 1, 1);
        #1 resetb = 1'b0;
        resetModel();
        #1;
        checkOutput("mid rst eff_bank", 32'(effBank), 32'h00);
        checkOutput("mid rst pagereg", 32'(pageReg), 32'h0);
        checkOutput("mid rst sel_hs", 32'(selHs), 32'h0);
        checkOutput("mid rst clk_div", 32'(clkDiv), 32'h0);
        tick();
        #2 resetb = 1'b1;
        regWrite(4'h0, 8'h04);
        applyStimulus(1, 1, 1, 8'hFF, 16'h0400, 8'h00, 0, 1);
        checkOutput("dcnt cleared by reset", 32'(selHs), 32'h1);
        tick();

        regWrite(4'h2, 8'hA3);
        regWrite(4'h3, 8'hFE);
        cycle(1, 1, 1, 8'h00, 16'hC800, 8'h00, 0, 1);
        applyStimulus(1, 0, 0, 8'h00, 16'h3000, 8'h11, 0, 1);
        checkOutput("mos bypass after VDU fetch", 32'(effBank), MosEn ? 32'h00 : 32'hFE);
        tick();
        cycle(1, 1, 1, 8'h00, 16'h8000, 8'h00, 0, 1);
        applyStimulus(1, 0, 0, 8'h00, 16'h3000, 8'h22, 0, 1);
        checkOutput("window after non-VDU fetch", 32'(effBank), 32'hFE);
        tick();

        for (int n = 0; n < 1500; n++) begin
            rnd = $urandom;
            case ($urandom_range(0, 5))
                0: begin b = 8'h80 | {2'b00, rnd[5:0]}; a = {rnd[31:20], rnd[11:8]}; end
                1, 2: begin b = 8'h00; a = rnd[31:16]; end
                3: begin b = 8'h00; a = 16'($urandom_range(16'hFC00, 16'hFEDF)); end
                4: begin b = 8'h00; a = 16'hFE30; end
                default: begin b = rnd[15:8]; a = rnd[31:16]; end
            endcase
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, rnd[6], b, a,
                  rnd[23:16], rnd[7], $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
